// File: rtl/mem_pkg.sv
// Shared types for the memory target: request opcode, default geometry,
// and the read-response bundle carried through the response FIFO.
package mem_pkg;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  localparam int MEM_WIDTH = 16;
  localparam int MEM_DEPTH = 64;

  typedef struct packed {
    logic [MEM_WIDTH-1:0] data;
    logic                 err;
  } mem_resp_t;

endpackage

// File: rtl/mem_resp_fifo.sv
// Response FIFO with a registered head (entry 0 is always the head).
// Ports: push/din in, pop in, head out, full/empty flags; sync active-low res.
module mem_resp_fifo #(
  parameter int W = 17,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(D + 1);
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  q [D];
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;
  logic [IW-1:0] wix;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(D));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = q[0];

  // On a simultaneous pop the tail slot moves down by one.
  assign wix = IW'(cnt - CW'(do_pop));

  always_ff @(posedge clk) begin
    if (!res) begin
      cnt <= '0;
      for (int i = 0; i < D; i++)
        q[i] <= '0;
    end else begin
      if (do_pop)
        for (int i = 0; i < D - 1; i++)
          q[i] <= q[i+1];
      if (do_push)
        q[wix] <= din;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_slave_pipe.sv
// Memory target: byte-strobed writes, fixed-latency reads into a response FIFO.
// Ports: valid/ready/wr_rd/addr/wdata/wstrb request, rdata/rerr/rvalid/rready resp.
module mem_slave_pipe
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  rerr,
  input  logic                  rready
);

  localparam int NB = WIDTH / 8;
  localparam int OW = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } resp_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [OW-1:0]    outstanding;
  logic             en;
  logic             in_rng;
  logic             acc;
  logic             acc_wr;
  logic             acc_rd;
  logic             pop;
  logic             push;
  logic             f_full;
  logic             f_empty;
  resp_t            cap;
  resp_t            push_d;
  resp_t            head;

  assign in_rng = ({1'b0, addr} < DEPTH_W);

  // en holds ready low for the first cycle after reset.
  assign ready  = en && (outstanding < OW'(RESP_DEPTH));
  assign acc    = res && valid && ready;
  assign acc_wr = acc && (mem_op_e'(wr_rd) == MEM_WR);
  assign acc_rd = acc && (mem_op_e'(wr_rd) == MEM_RD);

  assign rvalid = !f_empty;
  assign pop    = rvalid && rready;
  assign rdata  = head.data;
  assign rerr   = head.err;

  assign cap.data = in_rng ? mem[addr] : '0;
  assign cap.err  = !in_rng;

  always_ff @(posedge clk) begin
    if (acc_wr && in_rng)
      for (int b = 0; b < NB; b++)
        if (wstrb[b])
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      en          <= 1'b0;
      outstanding <= '0;
    end else begin
      en          <= 1'b1;
      outstanding <= outstanding + OW'(acc_rd) - OW'(pop);
    end
  end

  // The FIFO register supplies the last latency cycle,
  // so the shift pipe is RD_LATENCY-1 deep.
  generate
    if (RD_LATENCY == 1) begin : g_direct
      assign push   = acc_rd;
      assign push_d = cap;
    end else begin : g_pipe
      logic [RD_LATENCY-2:0] pv;
      resp_t                 pd [RD_LATENCY-1];

      always_ff @(posedge clk) begin
        if (!res) begin
          pv <= '0;
        end else begin
          pv[0] <= acc_rd;
          for (int i = 1; i < RD_LATENCY - 1; i++)
            pv[i] <= pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pd[0] <= cap;
        for (int i = 1; i < RD_LATENCY - 1; i++)
          pd[i] <= pd[i-1];
      end

      assign push   = pv[RD_LATENCY-2];
      assign push_d = pd[RD_LATENCY-2];
    end
  endgenerate

  mem_resp_fifo #(
    .W ($bits(resp_t)),
    .D (RESP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .din   (push_d),
    .pop   (pop),
    .head  (head),
    .full  (f_full),
    .empty (f_empty)
  );

  // Credits guarantee room; a push into a full FIFO is a design bug.
  always_ff @(posedge clk) begin
    if (res)
      assert (!(push && f_full && !pop));
  end

endmodule

// File: tb/tb_mem_slave_pipe.sv
// Scoreboard bench for mem_slave_pipe (DEPTH=48, RD_LATENCY=2, RESP_DEPTH=4).
// Accept monitor feeds a reference model; response monitor pops and compares.
module tb_mem_slave_pipe;

  localparam int W  = 16;
  localparam int D  = 48;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          valid = 1'b0;
  logic          wr_rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [1:0]    wstrb = '0;
  logic          rready = 1'b0;
  logic          ready;
  logic          rvalid;
  logic          rerr;
  logic [W-1:0]  rdata;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] model [D];
  int           total = 0;
  int           bad = 0;
  bit           acc_n = 1'b0;

  always #5 clk = ~clk;

  mem_slave_pipe #(
    .WIDTH      (W),
    .DEPTH      (D),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (2),
    .RESP_DEPTH (4)
  ) dut (
    .clk    (clk),
    .res    (res),
    .valid  (valid),
    .ready  (ready),
    .wr_rd  (wr_rd),
    .addr   (addr),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rerr   (rerr),
    .rready (rready)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Inputs change at posedge+1, so the negedge view predicts the accept.
  always @(negedge clk)
    acc_n = (res === 1'b1) && (valid === 1'b1) && (ready === 1'b1);

  // Reference model: writes land per byte lane, reads queue their answer.
  always @(posedge clk) begin
    exp_t e;
    if (!res) begin
      sb.delete();
    end else if (acc_n) begin
      if (wr_rd) begin
        if (int'(addr) < D)
          for (int b = 0; b < 2; b++)
            if (wstrb[b])
              model[addr][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        e.d = (int'(addr) < D) ? model[addr] : '0;
        e.e = (int'(addr) >= D);
        sb.push_back(e);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (res === 1'b1 && rvalid === 1'b1 && rready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid actual=%h required=none", rdata);
      end else begin
        e = sb.pop_front();
        chk("rdata", 32'(rdata), 32'(e.d));
        chk("rerr", 32'(rerr), 32'(e.e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit w, int a, logic [W-1:0] d, logic [1:0] s);
    valid = v;
    wr_rd = w;
    addr  = AW'(a);
    wdata = d;
    wstrb = s;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(0, 0, 0, '0, '0);
    rready = 1'b1;
    while ((sb.size() != 0 || rvalid) && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(n < 100), 32'd1);
  endtask

  initial begin
    logic [W-1:0] hold;

    res = 1'b0;
    repeat (3) cyc();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    res = 1'b1;
    cyc();
    chk("post_rst_ready", 32'(ready), 1);
    chk("post_rst_rvalid", 32'(rvalid), 0);

    rready = 1'b1;
    for (int a = 0; a < D; a++) begin
      drive(1, 1, a, W'($urandom), 2'b11);
      cyc();
    end

    // Full write then read, latency of exactly two cycles.
    drive(1, 1, 5, 16'hA5C3, 2'b11);
    cyc();
    drive(1, 0, 5, '0, '0);
    cyc();
    drive(0, 0, 0, '0, '0);
    chk("lat_t1_rvalid", 32'(rvalid), 0);
    cyc();
    chk("lat_t2_rvalid", 32'(rvalid), 1);
    chk("rd5_data", 32'(rdata), 32'h0000A5C3);
    chk("rd5_err", 32'(rerr), 0);

    // Partial strobe merge.
    drive(1, 1, 3, 16'hFFFF, 2'b11);
    cyc();
    drive(1, 1, 3, 16'h1234, 2'b01);
    cyc();
    drive(1, 0, 3, '0, '0);
    cyc();
    drive(0, 0, 0, '0, '0);
    cyc();
    chk("strb_rvalid", 32'(rvalid), 1);
    chk("strb_data", 32'(rdata), 32'h0000FF34);
    drain();

    // Fill the response path with rready low.
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i, '0, '0);
      cyc();
    end
    drive(0, 0, 0, '0, '0);
    chk("full_ready_low", 32'(ready), 0);
    chk("full_queued", 32'(sb.size()), 4);
    cyc();
    hold = rdata;
    repeat (3) cyc();
    chk("hold_rvalid", 32'(rvalid), 1);
    chk("hold_rdata", 32'(rdata), 32'(hold));
    chk("hold_ready", 32'(ready), 0);
    rready = 1'b1;
    cyc();
    chk("ready_back", 32'(ready), 1);
    drain();

    // Out-of-range accesses and boundary addresses.
    drive(1, 0, 50, '0, '0);
    cyc();
    drive(0, 0, 0, '0, '0);
    cyc();
    chk("oor_rvalid", 32'(rvalid), 1);
    chk("oor_rdata", 32'(rdata), 0);
    chk("oor_rerr", 32'(rerr), 1);
    drive(1, 1, 50, 16'hDEAD, 2'b11);
    cyc();
    drive(1, 0, 47, '0, '0);
    cyc();
    drive(1, 0, 48, '0, '0);
    cyc();
    for (int a = 0; a < D; a++) begin
      drive(1, 0, a, '0, '0);
      cyc();
    end
    drain();

    // Reset with reads in flight discards them.
    rready = 1'b0;
    drive(1, 0, 1, '0, '0);
    cyc();
    drive(1, 0, 2, '0, '0);
    cyc();
    drive(0, 0, 0, '0, '0);
    res = 1'b0;
    cyc();
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    chk("mid_rst_rerr", 32'(rerr), 0);
    chk("mid_rst_outst", 32'(dut.outstanding), 0);
    res = 1'b1;
    cyc();
    chk("mid_rst_ready_up", 32'(ready), 1);
    rready = 1'b1;
    repeat (6) cyc();
    chk("flushed_rvalid", 32'(rvalid), 0);
    chk("flushed_outst", 32'(dut.outstanding), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            $urandom_range(0, 55), W'($urandom), 2'($urandom));
      rready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
